// File: rtl/conv3x3_window_gen.sv
// 3x3 sliding-window generator: buffers two image rows and emits one packed
// window per interior pixel position, with first/last flags and a frame_done pulse.
module conv3x3_window_gen #(
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8,
   parameter int unsigned PIX_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PIX_W-1:0]     pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic [9*PIX_W-1:0]   win_out,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic                 win_first,
   output logic                 win_last,
   output logic                 frame_done
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam int unsigned WIN_W = 9 * PIX_W;

   logic [PIX_W-1:0] lb0_q [IMG_W];
   logic [PIX_W-1:0] lb1_q [IMG_W];

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [WIN_W-1:0] win_sr_q, win_sr_d;
   logic [WIN_W-1:0] win_out_q, win_out_d;
   logic             win_valid_q, win_valid_d;
   logic             win_first_q, win_first_d;
   logic             win_last_q, win_last_d;
   logic             frame_done_q, frame_done_d;

   logic accept;
   logic col_end;
   logic row_end;
   logic emit;

   // Single output stage: a held window stalls every incoming pixel.
   assign pix_ready = !win_valid_q || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign col_end   = (col_q == COL_W'(IMG_W - 1));
   assign row_end   = (row_q == ROW_W'(IMG_H - 1));
   assign emit      = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_sr_d     = win_sr_q;
      win_out_d    = win_out_q;
      win_valid_d  = win_valid_q && !win_ready;
      win_first_d  = win_first_q;
      win_last_d   = win_last_q;
      frame_done_d = 1'b0;

      if (accept) begin
         col_d        = col_end ? '0 : col_q + COL_W'(1);
         frame_done_d = col_end && row_end;
         if (col_end) begin
            row_d = row_end ? '0 : row_q + ROW_W'(1);
         end
         // Shift window left; new right column is {two rows up, one row up, current}.
         win_sr_d[PIX_W*0 +: PIX_W] = win_sr_q[PIX_W*1 +: PIX_W];
         win_sr_d[PIX_W*1 +: PIX_W] = win_sr_q[PIX_W*2 +: PIX_W];
         win_sr_d[PIX_W*3 +: PIX_W] = win_sr_q[PIX_W*4 +: PIX_W];
         win_sr_d[PIX_W*4 +: PIX_W] = win_sr_q[PIX_W*5 +: PIX_W];
         win_sr_d[PIX_W*6 +: PIX_W] = win_sr_q[PIX_W*7 +: PIX_W];
         win_sr_d[PIX_W*7 +: PIX_W] = win_sr_q[PIX_W*8 +: PIX_W];
         win_sr_d[PIX_W*2 +: PIX_W] = lb1_q[col_q];
         win_sr_d[PIX_W*5 +: PIX_W] = lb0_q[col_q];
         win_sr_d[PIX_W*8 +: PIX_W] = pix_in;
      end

      if (emit) begin
         win_out_d   = win_sr_d;
         win_valid_d = 1'b1;
         win_first_d = (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
         win_last_d  = row_end && col_end;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         win_sr_q     <= '0;
         win_out_q    <= '0;
         win_valid_q  <= 1'b0;
         win_first_q  <= 1'b0;
         win_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_sr_q     <= win_sr_d;
         win_out_q    <= win_out_d;
         win_valid_q  <= win_valid_d;
         win_first_q  <= win_first_d;
         win_last_q   <= win_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffers hold no reset; rows 0-1 of every frame overwrite them before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= pix_in;
      end
   end

   assign win_out    = win_out_q;
   assign win_valid  = win_valid_q;
   assign win_first  = win_first_q;
   assign win_last   = win_last_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Randomized bench for conv3x3_window_gen: 4x4 instance checked against an
// image-level window model, plus a 3x3 instance for the single-window case.
module tb_conv3x3_window_gen;

   localparam int unsigned N = 4;
   localparam int unsigned BUDGET = 3000;

   typedef struct packed {
      logic [71:0] win;
      logic        first;
      logic        last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  p4, p3;
   logic        pv4, pv3, pr4, pr3;
   logic [71:0] w4, w3;
   logic        wv4, wv3, wr4, wr3;
   logic        wf4, wf3, wl4, wl3;
   logic        fd4, fd3;

   int          n_cmp;
   int          n_err;
   int          fidx;
   int          fd_cnt;
   logic [7:0]  pix_q [$];
   exp_t        exp_q [$];
   logic [71:0] got_q [$];

   conv3x3_window_gen #(.IMG_W(N), .IMG_H(N), .PIX_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .pix_in(p4), .pix_valid(pv4), .pix_ready(pr4),
      .win_out(w4), .win_valid(wv4), .win_ready(wr4), .win_first(wf4),
      .win_last(wl4), .frame_done(fd4)
   );

   conv3x3_window_gen #(.IMG_W(3), .IMG_H(3), .PIX_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .pix_in(p3), .pix_valid(pv3), .pix_ready(pr3),
      .win_out(w3), .win_valid(wv3), .win_ready(wr3), .win_first(wf3),
      .win_last(wl3), .frame_done(fd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: every NxN frame yields windows built directly from the image array.
   task automatic push_frame(input logic [7:0] base, input bit rnd);
      logic [7:0] img [N*N];
      exp_t e;
      for (int i = 0; i < int'(N*N); i++) begin
         img[i] = rnd ? 8'($urandom) : base + 8'(i);
         pix_q.push_back(img[i]);
      end
      for (int r = 2; r < int'(N); r++) begin
         for (int c = 2; c < int'(N); c++) begin
            for (int rr = 0; rr < 3; rr++)
               for (int cc = 0; cc < 3; cc++)
                  e.win[8*(rr*3+cc) +: 8] = img[(r-2+rr)*int'(N) + (c-2+cc)];
            e.first = (r == 2) && (c == 2);
            e.last  = (r == int'(N)-1) && (c == int'(N)-1);
            exp_q.push_back(e);
         end
      end
   endtask

   // rmode: 0 always ready, 1 random ready, 2 stall window stall_idx for 5 cycles
   task automatic run(input int rmode, input int gap_pct, input int stall_idx);
      int          cyc = 0;
      int          consumed = 0;
      int          stall_left = 5;
      bit          prev_hold = 1'b0;
      bit          exp_fd = 1'b0;
      logic [71:0] prev_win = '0;
      exp_t        e;
      got_q.delete();
      while ((pix_q.size() > 0 || exp_q.size() > 0 || wv4) && cyc < int'(BUDGET)) begin
         @(posedge clk); #1;
         pv4 = (pix_q.size() > 0) && ($urandom_range(99) >= gap_pct);
         p4  = (pix_q.size() > 0) ? pix_q[0] : 8'($urandom);
         case (rmode)
            0: wr4 = 1'b1;
            1: wr4 = 1'($urandom_range(1));
            default: begin
               if (wv4 && consumed == stall_idx && stall_left > 0) begin
                  wr4 = 1'b0;
                  stall_left--;
               end else begin
                  wr4 = 1'b1;
               end
            end
         endcase
         @(negedge clk);
         check_eq("frame_done", 72'(fd4), 72'(exp_fd));
         check_eq("pix_ready", 72'(pr4), 72'(!wv4 || wr4));
         if (prev_hold) begin
            check_eq("hold_valid", 72'(wv4), 72'(1));
            check_eq("hold_win", w4, prev_win);
         end
         if (fd4) fd_cnt++;
         if (wv4 && wr4) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_win", 72'(1), 72'(0));
            end else begin
               e = exp_q.pop_front();
               check_eq("win", w4, e.win);
               check_eq("first", 72'(wf4), 72'(e.first));
               check_eq("last", 72'(wl4), 72'(e.last));
            end
            got_q.push_back(w4);
            consumed++;
         end
         prev_hold = wv4 && !wr4;
         prev_win  = w4;
         exp_fd    = 1'b0;
         if (pv4 && pr4) begin
            void'(pix_q.pop_front());
            if (fidx == int'(N*N) - 1) exp_fd = 1'b1;
            fidx = (fidx + 1) % int'(N*N);
         end
         cyc++;
      end
      if (cyc >= int'(BUDGET)) check_eq("timeout", 72'(cyc), 72'(0));
      pv4 = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_valid"}, 72'(wv4), 72'(0));
      check_eq({tag, "_win"}, w4, 72'(0));
      check_eq({tag, "_flags"}, 72'({wf4, wl4, fd4}), 72'(0));
      check_eq({tag, "_ready"}, 72'(pr4), 72'(1));
   endtask

   initial begin
      int cnt3;
      int idx3;
      int fd3_cnt;
      n_cmp = 0; n_err = 0; fidx = 0; fd_cnt = 0;
      rst_n = 1'b0;
      pv4 = 1'b0; p4 = '0; wr4 = 1'b1;
      pv3 = 1'b0; p3 = '0; wr3 = 1'b1;
      #23;
      check_idle("rst");
      @(posedge clk); #2 rst_n = 1'b1;

      // continuous 0x00..0x0F
      push_frame(8'h00, 1'b0);
      run(0, 0, -1);
      check_eq("t1_cnt", 72'(got_q.size()), 72'(4));
      if (got_q.size() == 4) begin
         check_eq("t1_w0", got_q[0], 72'h0A0908060504020100);
         check_eq("t1_w1", got_q[1], 72'h0B0A09070605030201);
         check_eq("t1_w2", got_q[2], 72'h0E0D0C0A0908060504);
         check_eq("t1_w3", got_q[3], 72'h0F0E0D0B0A09070605);
      end
      check_eq("t1_fd_cnt", 72'(fd_cnt), 72'(1));

      // output stall on second window
      push_frame(8'h00, 1'b0);
      run(2, 0, 1);
      check_eq("t2_cnt", 72'(got_q.size()), 72'(4));
      if (got_q.size() == 4) check_eq("t2_w1", got_q[1], 72'h0B0A09070605030201);

      // random input gaps
      push_frame(8'h00, 1'b0);
      run(0, 50, -1);
      check_eq("t3_cnt", 72'(got_q.size()), 72'(4));
      if (got_q.size() == 4) check_eq("t3_w3", got_q[3], 72'h0F0E0D0B0A09070605);

      // back-to-back frames
      push_frame(8'h00, 1'b0);
      push_frame(8'h10, 1'b0);
      run(0, 0, -1);
      check_eq("t4_cnt", 72'(got_q.size()), 72'(8));
      if (got_q.size() == 8) check_eq("t4_w4", got_q[4], 72'h1A1918161514121110);

      // asynchronous reset after pixel 0x07, then restart
      for (int i = 0; i < 8; i++) pix_q.push_back(8'(i));
      run(0, 0, -1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check_idle("rst_mid");
      @(posedge clk); #1 check_idle("rst_hold");
      #1 rst_n = 1'b1;
      fidx = 0;
      push_frame(8'h00, 1'b0);
      run(0, 0, -1);
      check_eq("t5_cnt", 72'(got_q.size()), 72'(4));
      if (got_q.size() == 4) check_eq("t5_w0", got_q[0], 72'h0A0908060504020100);

      // random data, gaps and backpressure over several frames
      for (int f = 0; f < 4; f++) push_frame(8'h00, 1'b1);
      run(1, 30, -1);
      check_eq("t6_cnt", 72'(got_q.size()), 72'(16));

      // 3x3 image: single window carrying both flags
      cnt3 = 0; idx3 = 0; fd3_cnt = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk); #1;
         pv3 = (idx3 < 9);
         p3  = 8'(idx3 + 1);
         @(negedge clk);
         if (wv3) begin
            cnt3++;
            check_eq("t7_win", w3, 72'h090807060504030201);
            check_eq("t7_flags", 72'({wf3, wl3}), 72'(2'b11));
         end
         if (fd3) fd3_cnt++;
         if (pv3 && pr3) idx3++;
      end
      pv3 = 1'b0;
      check_eq("t7_cnt", 72'(cnt3), 72'(1));
      check_eq("t7_fd", 72'(fd3_cnt), 72'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv3x3_window_gen.md
Name: conv3x3_window_gen

Overview:
- Streaming producer for the 3x3 convolution datapath.
- Accepts raster-order 8-bit ifmap pixels and buffers two full rows internally in line buffers.
- Emits one packed 72-bit 3x3 window per valid output position, plus a first-window flag.
- The 72-bit window and the first flag drive the conv top's ifmap_in and state inputs directly; this replaces file-driven window feeding.

Parameters:
- IMG_W, 8: image width in pixels, 3..256.
- IMG_H, 8: image height in rows, 3..256.
- PIX_W, 8: pixel width in bits. Window width is 9*PIX_W.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- pix_in, input, PIX_W: incoming pixel, raster order, row-major.
- pix_valid, input, 1: pix_in is valid this cycle.
- pix_ready, output, 1: block can accept a pixel this cycle.
- win_out, output, 9*PIX_W: packed 3x3 window.
- win_valid, output, 1: win_out holds a window.
- win_ready, input, 1: consumer accepts the window this cycle.
- win_first, output, 1: qualifies win_valid; high for the first window of a frame. Drives the conv state input.
- win_last, output, 1: qualifies win_valid; high for the last window of a frame.
- frame_done, output, 1: one-cycle pulse after the frame's last pixel is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - win_valid, win_first, win_last, frame_done = 0; win_out = 0.
  - col and row counters = 0; window shift registers = 0.
  - Line-buffer contents are don't-care.
  - pix_ready is combinational and = 1 when out of reset.
- Reset asserted mid-frame aborts the frame. The next accepted pixel is treated as (row 0, col 0).
- Pixel accept: pix_valid && pix_ready.
- Per accepted pixel p at (row, col):
  - Line buffers shift column col: lb1[col] <= lb0[col], lb0[col] <= p.
  - The window column shifts left. The new right column is, top to bottom, {lb1[col], lb0[col], p}, using old line-buffer values.
  - col increments. At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), row wraps to 0 and frame_done pulses next cycle.
- Window emit:
  - Emitted when the accepted pixel has row>=2 and col>=2.
  - Covers rows row-2..row and cols col-2..col.
  - Appears registered on the next cycle: latency 1 from the accepting edge.
- Packing:
  - Byte k = r*3+c occupies bits [PIX_W*k+PIX_W-1 : PIX_W*k].
  - r=0 is the top (oldest) row; c=0 is the left column.
  - Pixel (row-2, col-2) is byte 0; pixel (row, col) is byte 8.
- Windows per frame: (IMG_H-2)*(IMG_W-2).
  - win_first = 1 only on window (2,2).
  - win_last = 1 only on window (IMG_H-1, IMG_W-1).
  - For a 3x3 image, both flags are set on the single window.
- Handshake:
  - pix_ready = !win_valid || win_ready (single output stage).
  - win_out, win_first, win_last hold stable while win_valid && !win_ready.
  - win_valid clears on win_ready unless a new window is loaded in the same cycle. A simultaneous consume and load gives back-to-back windows with win_valid staying 1.
  - Pixels that do not produce a window are still stalled while the output is held. This keeps ordering simple.
- Gaps in pix_valid: no state change, no output change beyond the handshake.
- Frames run back to back with no idle cycle required. The first pixel of the next frame may be accepted in the same cycle frame_done is high.
- Rows 0–1 and cols 0–1 of each row only fill the buffers. Stale line-buffer data from a previous frame never appears in an emitted window.

Test Plan:
- IMG_W=IMG_H=4, pixels 0x00..0x0F streamed continuously, win_ready=1 -> four windows:
  - 72'h0A0908060504020100 (win_first=1)
  - 72'h0B0A09070605030201
  - 72'h0E0D0C0A0908060504
  - 72'h0F0E0D0B0A09070605 (win_last=1)
  - frame_done pulses once, one cycle after pixel 0x0F is accepted.
- Same stream, win_ready held low 5 cycles on the 2nd window -> win_out stable at 72'h0B0A09070605030201, pix_ready=0 throughout, no pixel lost, remaining windows identical to the first test.
- Random pix_valid gaps (~50% duty) on the 4x4 stream -> identical window sequence and flags; win_valid count = 4.
- Two 4x4 frames back to back, second frame pixels 0x10..0x1F -> second frame's first window = 72'h1A1918161514121110 with win_first=1, no window mixing frames.
- rst_n pulsed low asynchronously after pixel 0x07, then a full 4x4 frame restarted -> outputs 0 during reset, first window after restart = 72'h0A0908060504020100.
- IMG_W=IMG_H=3, pixels 1..9 -> single window 72'h090807060504030201 with win_first=1 and win_last=1.
